// File: rtl/axi4_defs_pkg.sv
// rtl/axi4_defs_pkg.sv - shared AXI4 constants, fetch FSM states and 4KB page helper
package axi4_defs_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_PAGE_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FLUSH
    } fetch_state_t;

    // Words left before the next 4KB boundary (1..1024).
    function automatic logic [23:0] page_words(input logic [11:0] offset);
        logic [12:0] room;
        room = 13'(AXI_PAGE_BYTES) - {1'b0, offset};
        return 24'(room >> 2);
    endfunction

endpackage

// File: rtl/axi4_frame_fetch_if.sv
// rtl/axi4_frame_fetch_if.sv - AR/R master channels and output word stream of the frame fetcher
interface axi4_frame_fetch_if;
    logic        outport_arvalid_o;
    logic        outport_arready_i;
    logic [31:0] outport_araddr_o;
    logic [3:0]  outport_arid_o;
    logic [7:0]  outport_arlen_o;
    logic [1:0]  outport_arburst_o;
    logic        outport_rvalid_i;
    logic [31:0] outport_rdata_i;
    logic [1:0]  outport_rresp_i;
    logic [3:0]  outport_rid_i;
    logic        outport_rlast_i;
    logic        outport_rready_o;
    logic        stream_valid_o;
    logic [31:0] stream_data_o;
    logic        stream_ready_i;

    modport master (
        output outport_arvalid_o, outport_araddr_o, outport_arid_o, outport_arlen_o,
               outport_arburst_o, outport_rready_o, stream_valid_o, stream_data_o,
        input  outport_arready_i, outport_rvalid_i, outport_rdata_i, outport_rresp_i,
               outport_rid_i, outport_rlast_i, stream_ready_i
    );

    modport slave (
        input  outport_arvalid_o, outport_araddr_o, outport_arid_o, outport_arlen_o,
               outport_arburst_o, outport_rready_o, stream_valid_o, stream_data_o,
        output outport_arready_i, outport_rvalid_i, outport_rdata_i, outport_rresp_i,
               outport_rid_i, outport_rlast_i, stream_ready_i
    );
endinterface

// File: rtl/axi4_frame_fetch_fifo.sv
// rtl/axi4_frame_fetch_fifo.sv - registered synchronous word FIFO with occupancy count
module axi4_frame_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s_tvalid,
    input  logic [WIDTH-1:0]           s_tdata,
    output logic                       m_tvalid,
    output logic [WIDTH-1:0]           m_tdata,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && (count != (AW+1)'(DEPTH));
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/axi4_frame_fetch.sv
// rtl/axi4_frame_fetch.sv - AXI4 read DMA: 4KB-safe INCR bursts with FIFO credit, word stream out
module axi4_frame_fetch
    import axi4_defs_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int AXI_ID     = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_start_i,
    input  logic [31:0]         cfg_addr_i,
    input  logic [23:0]         cfg_words_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    axi4_frame_fetch_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   addr_q;
    logic [23:0]   remaining_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] fifo_count;
    logic          arvalid_q;
    logic [31:0]   araddr_q;
    logic [7:0]    arlen_q;
    logic          rready_q;
    logic          error_q;
    logic          zero_done_q;

    logic [23:0]   beats;
    logic [23:0]   credit;
    logic [CW-1:0] add_beats;
    logic          ar_hs, r_beat, issue, job_start, flush_done;
    logic          unused_ok;

    assign unused_ok = &{1'b0, bus.outport_rid_i, bus.outport_rlast_i, cfg_addr_i[1:0]};

    always_comb begin
        beats = 24'(BURST_LEN);
        if (remaining_q < beats) beats = remaining_q;
        if (page_words(addr_q[11:0]) < beats) beats = page_words(addr_q[11:0]);
    end

    // Outstanding counts beats from issue time, so FIFO space is reserved before AR goes out.
    assign credit     = 24'(FIFO_DEPTH) - 24'(fifo_count) - 24'(outstanding_q);
    assign ar_hs      = arvalid_q && bus.outport_arready_i;
    assign r_beat     = bus.outport_rvalid_i && rready_q;
    assign job_start  = (state_q == ST_IDLE) && cfg_start_i;
    assign issue      = (state_q == ST_ISSUE) && (remaining_q != '0) &&
                        (!arvalid_q || ar_hs) && (credit >= beats);
    assign flush_done = (state_q == ST_FLUSH) && (outstanding_q == '0) && !arvalid_q;
    assign add_beats  = issue ? CW'(beats) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (job_start && cfg_words_i != '0) state_d = ST_ISSUE;
            ST_ISSUE: if (issue && remaining_q == beats)  state_d = ST_FLUSH;
            ST_FLUSH: if (flush_done)                     state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            rready_q      <= 1'b0;
            error_q       <= 1'b0;
            zero_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rready_q    <= 1'b1;
            zero_done_q <= job_start && (cfg_words_i == '0);
            if (job_start) begin
                addr_q      <= {cfg_addr_i[31:2], 2'b00};
                remaining_q <= cfg_words_i;
                error_q     <= 1'b0;
            end else if (issue) begin
                addr_q      <= addr_q + (32'(beats) << 2);
                remaining_q <= remaining_q - beats;
            end
            if (issue) begin
                arvalid_q <= 1'b1;
                araddr_q  <= addr_q;
                arlen_q   <= 8'(beats - 24'd1);
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            outstanding_q <= outstanding_q + add_beats - CW'(r_beat);
            if (r_beat && bus.outport_rresp_i != AXI_RESP_OKAY) error_q <= 1'b1;
        end
    end

    axi4_frame_fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .s_tvalid (r_beat),
        .s_tdata  (bus.outport_rdata_i),
        .m_tvalid (bus.stream_valid_o),
        .m_tdata  (bus.stream_data_o),
        .m_tready (bus.stream_ready_i),
        .count    (fifo_count)
    );

    assign bus.outport_arvalid_o = arvalid_q;
    assign bus.outport_araddr_o  = araddr_q;
    assign bus.outport_arlen_o   = arlen_q;
    assign bus.outport_arid_o    = 4'(AXI_ID);
    assign bus.outport_arburst_o = AXI_BURST_INCR;
    assign bus.outport_rready_o  = rready_q;
    assign busy_o                = (state_q != ST_IDLE);
    assign done_o                = flush_done || zero_done_q;
    assign error_o               = error_q;
endmodule

// File: tb/tb_axi4_frame_fetch.sv
// tb/tb_axi4_frame_fetch.sv - self-checking bench: memory slave, reference burst/word model, directed and random jobs
module tb_axi4_frame_fetch;
    localparam int BURST_LEN  = 16;
    localparam int FIFO_DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [31:0] cfg_addr;
    logic [23:0] cfg_words;
    logic        busy, done, error;

    always #5 clk = ~clk;

    axi4_frame_fetch_if bus();

    axi4_frame_fetch #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .AXI_ID(0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_start_i (cfg_start),
        .cfg_addr_i  (cfg_addr),
        .cfg_words_i (cfg_words),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .bus         (bus)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct {
        logic [31:0] addr;
        int          words;
        int          err_beat;
        int          exp_bursts;
        logic        exp_err;
        int          stall;
    } vec_t;

    int checks = 0;
    int errors = 0;

    ar_t         exp_ar[$];
    logic [31:0] exp_words[$];
    logic [31:0] r_pend[$];
    int          ar_mode, r_rand, sink_mode;
    int          r_beat_idx, err_beat, done_cnt, ar_cnt, req_beats, fill;
    logic        err_at_done;
    logic        start_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected by the model", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Reference: split [addr, addr+4*words) into bursts of at most BURST_LEN that never cross 4KB.
    task automatic build_model(input logic [31:0] addr, input int words);
        logic [31:0] a;
        int rem, b, room;
        a = addr & 32'hFFFF_FFFC;
        rem = words;
        exp_ar.delete();
        exp_words.delete();
        for (int i = 0; i < words; i++) exp_words.push_back(mem_word(a + 32'(4 * i)));
        while (rem > 0) begin
            b = BURST_LEN;
            if (rem < b) b = rem;
            room = (4096 - int'(a[11:0])) / 4;
            if (room < b) b = room;
            exp_ar.push_back('{a, 8'(b - 1)});
            a = a + 32'(4 * b);
            rem -= b;
        end
    endtask

    task automatic step();
        ar_t e;
        logic [31:0] w;
        @(negedge clk);
        cfg_start = start_req;
        start_req = 1'b0;
        case (ar_mode)
            0:       bus.outport_arready_i = 1'b1;
            1:       bus.outport_arready_i = ($urandom_range(0, 3) != 0);
            default: bus.outport_arready_i = 1'b0;
        endcase
        bus.outport_rid_i   = 4'($urandom);
        bus.outport_rlast_i = 1'($urandom);
        if (r_pend.size() != 0 && (r_rand == 0 || $urandom_range(0, 3) != 0)) begin
            bus.outport_rvalid_i = 1'b1;
            bus.outport_rdata_i  = mem_word(r_pend[0]);
            bus.outport_rresp_i  = (r_beat_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
            bus.outport_rvalid_i = 1'b0;
            bus.outport_rdata_i  = $urandom;
            bus.outport_rresp_i  = 2'($urandom);
        end
        bus.stream_ready_i = (sink_mode == 1) ? 1'b1 :
                             (sink_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
        #1;
        if (!rst) check("rready_high", bus.outport_rready_o, 1);
        if (done) begin
            done_cnt++;
            err_at_done = error;
        end
        if (bus.outport_arvalid_o && bus.outport_arready_i) begin
            ar_cnt++;
            req_beats += int'(bus.outport_arlen_o) + 1;
            if (exp_ar.size() == 0) fail_now("ar_extra");
            else begin
                e = exp_ar.pop_front();
                check("araddr", bus.outport_araddr_o, e.addr);
                check("arlen", bus.outport_arlen_o, e.len);
            end
            check("arburst", bus.outport_arburst_o, 2'b01);
            check("arid", bus.outport_arid_o, 4'd0);
            for (int i = 0; i <= int'(bus.outport_arlen_o); i++)
                r_pend.push_back(bus.outport_araddr_o + 32'(4 * i));
        end
        if (bus.outport_rvalid_i && bus.outport_rready_o) begin
            void'(r_pend.pop_front());
            r_beat_idx++;
            fill++;
        end
        if (bus.stream_valid_o && bus.stream_ready_i) begin
            if (exp_words.size() == 0) fail_now("stream_extra");
            else begin
                w = exp_words.pop_front();
                check("stream_data", bus.stream_data_o, w);
            end
            fill--;
        end
        if (fill > FIFO_DEPTH) fail_now("fifo_overflow");
    endtask

    task automatic run_job(input logic [31:0] addr, input int words, input int errb,
                           input int exp_nb, input logic exp_err, input int stall, input int rnd);
        int n;
        build_model(addr, words);
        err_beat = errb; r_beat_idx = 0; done_cnt = 0; ar_cnt = 0; req_beats = 0;
        err_at_done = 1'b0;
        ar_mode = rnd; r_rand = rnd;
        sink_mode = (stall > 0) ? 0 : (rnd != 0 ? 2 : 1);
        cfg_addr = addr; cfg_words = 24'(words); start_req = 1'b1;
        step();
        step();
        check("busy_after_start", busy, 1);
        check("error_cleared_on_start", error, 0);
        if (stall > 0) begin
            repeat (stall) step();
            check("stall_req_beats", req_beats, FIFO_DEPTH);
            sink_mode = 1;
        end
        n = 0;
        while ((done_cnt == 0 || exp_words.size() != 0) && n < 6000) begin
            step();
            n++;
        end
        if (n >= 6000) fail_now("job_timeout");
        repeat (3) step();
        check("done_pulses", done_cnt, 1);
        check("busy_idle", busy, 0);
        check("ar_left", exp_ar.size(), 0);
        check("words_left", exp_words.size(), 0);
        check("error_at_done", err_at_done, exp_err);
        check("error_sticky", error, exp_err);
        if (exp_nb >= 0) check("burst_count", ar_cnt, exp_nb);
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] a;
        int words, errb, n;

        vecs[0] = '{32'h0000_1000,  40, -1,  3, 1'b0,   0};
        vecs[1] = '{32'h0000_1FF8,   8, -1,  2, 1'b0,   0};
        vecs[2] = '{32'h0000_2000,  20,  2,  2, 1'b1,   0};
        vecs[3] = '{32'h0000_5000,  12, -1,  1, 1'b0,   0};
        vecs[4] = '{32'hFFFF_FFF0,  10, -1,  2, 1'b0,   0};
        vecs[5] = '{32'h0000_1003,   3, -1,  1, 1'b0,   0};
        vecs[6] = '{32'h0000_4000, 200, -1, 13, 1'b0, 300};

        rst = 1'b1; cfg_start = 1'b0; cfg_addr = '0; cfg_words = '0;
        bus.outport_arready_i = 1'b0; bus.outport_rvalid_i = 1'b0; bus.outport_rdata_i = '0;
        bus.outport_rresp_i = '0; bus.outport_rid_i = '0; bus.outport_rlast_i = 1'b0;
        bus.stream_ready_i = 1'b0;
        ar_mode = 0; r_rand = 0; sink_mode = 1; fill = 0; err_beat = -1; r_beat_idx = 0;
        done_cnt = 0; ar_cnt = 0; req_beats = 0; err_at_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_arvalid", bus.outport_arvalid_o, 0);
        check("rst_araddr", bus.outport_araddr_o, 0);
        check("rst_arlen", bus.outport_arlen_o, 0);
        check("rst_arid", bus.outport_arid_o, 0);
        check("rst_arburst", bus.outport_arburst_o, 2'b01);
        check("rst_rready", bus.outport_rready_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_stream_valid", bus.stream_valid_o, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].addr, vecs[i].words, vecs[i].err_beat, vecs[i].exp_bursts,
                    vecs[i].exp_err, vecs[i].stall, 0);

        // Zero-length job: done one cycle after start, never busy, no AR.
        build_model(32'h0000_8000, 0);
        done_cnt = 0; ar_cnt = 0;
        cfg_addr = 32'h0000_8000; cfg_words = '0; start_req = 1'b1;
        step();
        step();
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_single", done, 0);
        repeat (4) step();
        check("zero_ar_count", ar_cnt, 0);

        // Reset while an AR is held pending.
        build_model(32'h0000_3000, 100);
        ar_mode = 2; r_rand = 0; sink_mode = 1;
        cfg_addr = 32'h0000_3000; cfg_words = 24'd100; start_req = 1'b1;
        step();
        n = 0;
        while (!bus.outport_arvalid_o && n < 20) begin
            step();
            n++;
        end
        check("mid_arvalid_seen", bus.outport_arvalid_o, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_arvalid", bus.outport_arvalid_o, 0);
        check("async_araddr", bus.outport_araddr_o, 0);
        check("async_arlen", bus.outport_arlen_o, 0);
        check("async_busy", busy, 0);
        check("async_rready", bus.outport_rready_o, 0);
        check("async_stream_valid", bus.stream_valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        r_pend.delete();
        fill = 0;
        ar_mode = 0;
        step();
        run_job(32'h0000_3000, 20, -1, 2, 1'b0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            if (k % 2 == 0) a[11:0] = 12'hFF0 - 12'(4 * $urandom_range(0, 8));
            words = $urandom_range(1, 120);
            errb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, words - 1) : -1;
            run_job(a, words, errb, -1, (errb >= 0), 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
